// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bus bundle between the MEM-stage front end, the EX/MEM
//                pipeline register and DataMemory. The slave modport is the
//                access unit. The master modport is its environment: the
//                pipeline and the data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    // Request side (from EX/MEM)
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // DataMemory side
    logic [31:0] dm_rdata;
    logic        dm_read;
    logic        dm_write;
    logic [2:0]  dm_func3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    // Results back to the pipeline
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    modport master (
        output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        output dm_rdata,
        input  dm_read, dm_write, dm_func3, dm_addr, dm_wdata,
        input  rdata, stall, fault
    );

    modport slave (
        input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata,
        input  dm_rdata,
        output dm_read, dm_write, dm_func3, dm_addr, dm_wdata,
        output rdata, stall, fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage front end for DataMemory. Aligned accesses pass
//                straight through in one cycle. Misaligned half/word accesses
//                are split into byte accesses over N cycles while the
//                pipeline is stalled. Out-of-range and illegal requests raise
//                a one-cycle fault and never reach memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    localparam logic [2:0]  C_F3_B      = 3'd0;
    localparam logic [2:0]  C_F3_H      = 3'd1;
    localparam logic [2:0]  C_F3_W      = 3'd2;
    localparam logic [2:0]  C_F3_BU     = 3'd4;
    localparam logic [2:0]  C_F3_HU     = 3'd5;
    localparam logic [32:0] C_LAST_ADDR = 33'(MEM_BYTES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [2:0]  lat_funct3_q, lat_funct3_d;
    logic        lat_write_q, lat_write_d;
    logic [23:0] buf_q, buf_d;          // bytes 0..2 of a split load

    // Request decode (only meaningful in IDLE)
    logic [1:0]  w_req_last;            // access size minus one
    logic        w_req_legal;
    logic        w_req_access;
    logic        w_req_range_bad;
    logic        w_req_fault;
    logic        w_req_misaligned;
    logic [1:0]  w_lat_last;            // size minus one of the latched access
    logic [7:0]  w_lat_wbyte;           // store byte selected by the counter

    // Access size minus one; the illegal codes fault anyway, size is moot
    function automatic logic [1:0] size_m1(input logic [2:0] f3);
        case (f3)
            C_F3_B, C_F3_BU: size_m1 = 2'd0;
            C_F3_H, C_F3_HU: size_m1 = 2'd1;
            default:         size_m1 = 2'd3;
        endcase
    endfunction

    // Sign/zero extension of an assembled little-endian split load
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            C_F3_H:  extend_load = {{16{raw[15]}}, raw[15:0]};
            C_F3_HU: extend_load = {16'h0000, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // Classify the incoming request: legality, range and alignment
    always_comb begin
        w_req_last       = size_m1(bus.req_funct3);
        w_req_access     = bus.req_valid & (bus.req_read | bus.req_write);
        if (bus.req_read) begin
            w_req_legal = (bus.req_funct3 == C_F3_B)  || (bus.req_funct3 == C_F3_H)  ||
                          (bus.req_funct3 == C_F3_W)  || (bus.req_funct3 == C_F3_BU) ||
                          (bus.req_funct3 == C_F3_HU);
        end else begin
            w_req_legal = (bus.req_funct3 == C_F3_B)  || (bus.req_funct3 == C_F3_H)  ||
                          (bus.req_funct3 == C_F3_W);
        end
        // 33-bit sum so an address near 2^32 cannot wrap back into range
        w_req_range_bad  = ({1'b0, bus.req_addr} + {31'b0, w_req_last}) > C_LAST_ADDR;
        w_req_fault      = w_req_access &
                           ((bus.req_read & bus.req_write) | ~w_req_legal | w_req_range_bad);
        // Low address bits under the size mask must be zero for alignment
        w_req_misaligned = (bus.req_addr[1:0] & w_req_last) != 2'b00;
    end

    // Latched-request helpers for the split sequence
    always_comb begin
        w_lat_last = size_m1(lat_funct3_q);
        case (cnt_q)
            2'd0:    w_lat_wbyte = lat_wdata_q[7:0];
            2'd1:    w_lat_wbyte = lat_wdata_q[15:8];
            2'd2:    w_lat_wbyte = lat_wdata_q[23:16];
            default: w_lat_wbyte = lat_wdata_q[31:24];
        endcase
    end

    // Next-state, memory-port and pipeline-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_funct3_d = lat_funct3_q;
        lat_write_d  = lat_write_q;
        buf_d        = buf_q;

        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        bus.dm_func3 = 3'd0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
        bus.rdata    = 32'h0;
        bus.stall    = 1'b0;
        bus.fault    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req_fault) begin
                    bus.fault = 1'b1;
                end else if (w_req_access && !w_req_misaligned) begin
                    // Aligned: pure pass-through, zero added latency
                    bus.dm_read  = bus.req_read;
                    bus.dm_write = bus.req_write;
                    bus.dm_func3 = bus.req_funct3;
                    bus.dm_addr  = bus.req_addr;
                    bus.dm_wdata = bus.req_wdata;
                    bus.rdata    = bus.dm_rdata;
                end else if (w_req_access) begin
                    // Misaligned: byte 0 now, the rest from latched copies
                    bus.dm_read  = bus.req_read;
                    bus.dm_write = bus.req_write;
                    bus.dm_func3 = bus.req_read ? C_F3_BU : C_F3_B;
                    bus.dm_addr  = bus.req_addr;
                    bus.dm_wdata = {24'h0, bus.req_wdata[7:0]};
                    bus.stall    = 1'b1;
                    lat_addr_d   = bus.req_addr;
                    lat_wdata_d  = bus.req_wdata;
                    lat_funct3_d = bus.req_funct3;
                    lat_write_d  = bus.req_write;
                    buf_d        = {16'h0, bus.req_read ? bus.dm_rdata[7:0] : 8'h00};
                    cnt_d        = 2'd1;
                    state_d      = ST_SPLIT;
                end
            end

            ST_SPLIT: begin
                bus.dm_read  = ~lat_write_q;
                bus.dm_write = lat_write_q;
                bus.dm_func3 = lat_write_q ? C_F3_B : C_F3_BU;
                bus.dm_addr  = lat_addr_q + {30'h0, cnt_q};
                bus.dm_wdata = {24'h0, w_lat_wbyte};
                if (cnt_q != w_lat_last) begin
                    bus.stall = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    if (!lat_write_q) begin
                        case (cnt_q)
                            2'd1:    buf_d[15:8]  = bus.dm_rdata[7:0];
                            2'd2:    buf_d[23:16] = bus.dm_rdata[7:0];
                            default: buf_d[7:0]   = bus.dm_rdata[7:0];
                        endcase
                    end
                end else begin
                    // Final byte comes straight from memory this cycle
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                    if (!lat_write_q) begin
                        if (w_lat_last == 2'd1) begin
                            bus.rdata = extend_load(lat_funct3_q,
                                                    {16'h0, bus.dm_rdata[7:0], buf_q[7:0]});
                        end else begin
                            bus.rdata = extend_load(lat_funct3_q,
                                                    {bus.dm_rdata[7:0], buf_q});
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // Reset silences the memory port and the pipeline outputs at once
        if (rst) begin
            bus.dm_read  = 1'b0;
            bus.dm_write = 1'b0;
            bus.rdata    = 32'h0;
            bus.stall    = 1'b0;
            bus.fault    = 1'b0;
        end
    end

    // State, counter, latched request and load-byte buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            lat_addr_q   <= 32'h0;
            lat_wdata_q  <= 32'h0;
            lat_funct3_q <= 3'd0;
            lat_write_q  <= 1'b0;
            buf_q        <= 24'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_funct3_q <= lat_funct3_d;
            lat_write_q  <= lat_write_d;
            buf_q        <= buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. A byte-array
//                DataMemory answers the DUT. A separate reference memory is
//                updated from whole-transaction load/store semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int C_MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_BYTES(C_MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  dm_mem  [C_MEM_BYTES];   // memory the DUT actually talks to
    logic [7:0]  ref_mem [C_MEM_BYTES];   // expected memory contents
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata;
    int          rd_idx;

    // DataMemory: combinational read, address wrapped into the array
    always_comb begin
        rd_idx = int'(bus.dm_addr % C_MEM_BYTES);
        case (bus.dm_func3)
            3'd0:    bus.dm_rdata = {{24{dm_mem[rd_idx][7]}}, dm_mem[rd_idx]};
            3'd1:    bus.dm_rdata = {{16{dm_mem[(rd_idx+1)%C_MEM_BYTES][7]}},
                                     dm_mem[(rd_idx+1)%C_MEM_BYTES], dm_mem[rd_idx]};
            3'd4:    bus.dm_rdata = {24'h0, dm_mem[rd_idx]};
            3'd5:    bus.dm_rdata = {16'h0, dm_mem[(rd_idx+1)%C_MEM_BYTES], dm_mem[rd_idx]};
            default: bus.dm_rdata = {dm_mem[(rd_idx+3)%C_MEM_BYTES], dm_mem[(rd_idx+2)%C_MEM_BYTES],
                                     dm_mem[(rd_idx+1)%C_MEM_BYTES], dm_mem[rd_idx]};
        endcase
    end

    // DataMemory: write on the clock edge
    always @(posedge clk) begin
        if (bus.dm_write) begin
            for (int i = 0; i < (bus.dm_func3 == 3'd0 ? 1 : bus.dm_func3 == 3'd1 ? 2 : 4); i++) begin
                dm_mem[(int'(bus.dm_addr % C_MEM_BYTES) + i) % C_MEM_BYTES] = 8'(bus.dm_wdata >> (8*i));
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int access_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < access_bytes(f3); i++)
            v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
        case (f3)
            3'd0:    return {{24{v[7]}}, v[7:0]};
            3'd1:    return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < access_bytes(f3); i++)
            ref_mem[int'(addr) + i] = 8'(wdata >> (8*i));
    endtask

    // One pipeline request held until the DUT releases stall
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          n, cyc, guard;
        bit          legal, flt, mis;
        longint      last_byte;
        logic [31:0] exp_rd;
        n         = access_bytes(f3);
        legal     = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        last_byte = longint'({32'h0, addr}) + n - 1;
        flt       = (rd && wr) || !legal || (last_byte > C_MEM_BYTES - 1);
        mis       = !flt && ((addr % n) != 0);
        cyc       = mis ? n : 1;
        exp_rd    = (rd && !flt) ? ref_load(f3, addr) : 32'h0;

        bus.req_valid  = 1'b1;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            check_eq("stall", 32'(bus.stall), 32'(k < cyc - 1));
            check_eq("fault", 32'(bus.fault), 32'(flt));
            check_eq("dm_read", 32'(bus.dm_read), 32'(rd && !flt));
            check_eq("dm_write", 32'(bus.dm_write), 32'(wr && !flt));
            if (!flt) begin
                check_eq("dm_addr", bus.dm_addr, addr + 32'(k));
                check_eq("dm_func3", 32'(bus.dm_func3), mis ? (rd ? 32'd4 : 32'd0) : 32'(f3));
                if (wr && mis)  check_eq("dm_wdata_byte", 32'(bus.dm_wdata[7:0]), 32'(8'(wdata >> (8*k))));
                if (wr && !mis) check_eq("dm_wdata", bus.dm_wdata, wdata);
            end
            if (k == cyc - 1 && (rd || flt)) check_eq("rdata", bus.rdata, exp_rd);
            last_rdata = bus.rdata;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        guard = 0;
        while (bus.stall !== 1'b0 && guard < 8) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard == 8) check_eq("stall_release", 32'(bus.stall), 32'h0);
        if (wr && !flt) ref_store(f3, addr, wdata);
    endtask

    task automatic idle_cycle();
        bus.req_valid  = 1'b0;
        bus.req_read   = 1'($urandom);
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        @(negedge clk);
        check_eq("idle_stall", 32'(bus.stall), 32'h0);
        check_eq("idle_fault", 32'(bus.fault), 32'h0);
        check_eq("idle_dm_rw", {30'h0, bus.dm_read, bus.dm_write}, 32'h0);
        check_eq("idle_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so a wedged run still ends
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rd, wr, both;
        logic [2:0]  f3;
        logic [31:0] addr, w_word, r_word;

        for (int i = 0; i < C_MEM_BYTES; i++) begin
            dm_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        dm_mem[0] = 8'd17;  ref_mem[0] = 8'd17;
        dm_mem[4] = 8'd9;   ref_mem[4] = 8'd9;
        dm_mem[8] = 8'd25;  ref_mem[8] = 8'd25;

        // Reset holds every output quiet even with a live request
        bus.req_valid  = 1'b1;
        bus.req_read   = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'd5;
        bus.req_wdata  = 32'h0;
        @(negedge clk);
        check_eq("rst_stall", 32'(bus.stall), 32'h0);
        check_eq("rst_dm_read", 32'(bus.dm_read), 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        bus.req_write = 1'b1;
        #1;
        check_eq("rst_fault", 32'(bus.fault), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        rst = 1'b0;

        // Directed scenarios
        run_txn(1, 0, 3'd2, 32'd8, 32'h0);
        check_eq("lw8_const", last_rdata, 32'h0000_0019);
        run_txn(1, 0, 3'd2, 32'd5, 32'h0);
        check_eq("lw5_const", last_rdata, 32'h1900_0000);
        run_txn(0, 1, 3'd1, 32'd7, 32'h0000_80FF);
        run_txn(1, 0, 3'd1, 32'd7, 32'h0);
        check_eq("lh7_const", last_rdata, 32'hFFFF_80FF);
        run_txn(1, 0, 3'd5, 32'd7, 32'h0);
        check_eq("lhu7_const", last_rdata, 32'h0000_80FF);
        run_txn(1, 0, 3'd2, 32'd1022, 32'h0);
        run_txn(1, 0, 3'd3, 32'd0, 32'h0);
        run_txn(1, 1, 3'd2, 32'd0, 32'h0);
        run_txn(0, 1, 3'd4, 32'd0, 32'h0);
        run_txn(1, 0, 3'd2, 32'd1020, 32'h0);
        run_txn(1, 0, 3'd4, 32'd1023, 32'h0);
        run_txn(1, 0, 3'd1, 32'd1023, 32'h0);
        run_txn(1, 0, 3'd2, 32'hFFFF_FFFE, 32'h0);
        idle_cycle();

        // Reset in the third cycle of a split store abandons the rest
        bus.req_valid  = 1'b1;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'd1;
        bus.req_wdata  = 32'hAABB_CCDD;
        @(negedge clk);
        check_eq("sw_rst_stall0", 32'(bus.stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("sw_rst_addr1", bus.dm_addr, 32'd2);
        check_eq("sw_rst_stall1", 32'(bus.stall), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("sw_rst_stall2", 32'(bus.stall), 32'h0);
        check_eq("sw_rst_write2", 32'(bus.dm_write), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("sw_rst_idle", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        ref_mem[1] = 8'hDD;
        ref_mem[2] = 8'hCC;
        run_txn(1, 0, 3'd2, 32'd0, 32'h0);
        check_eq("sw_rst_word0", last_rdata, 32'h00CC_DD11);

        // Randomized traffic against the reference memory
        for (int t = 0; t < 400; t++) begin
            both = ($urandom_range(0, 15) == 0);
            rd   = both | 1'($urandom);
            wr   = both | ~rd;
            if ($urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1, 2:    addr = 32'($urandom_range(C_MEM_BYTES - 8, C_MEM_BYTES - 1));
                default: addr = 32'($urandom_range(0, C_MEM_BYTES - 1));
            endcase
            run_txn(rd, wr, f3, addr, $urandom);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        // Memory image written by the DUT must match the reference image
        for (int w = 0; w < C_MEM_BYTES / 4; w++) begin
            w_word = {dm_mem[4*w+3], dm_mem[4*w+2], dm_mem[4*w+1], dm_mem[4*w]};
            r_word = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            check_eq("mem_image", w_word, r_word);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
